imem_loader: RTL and testbench

- Writer side of the instruction-memory interface that the pipelined CPU fetch stage reads from.
- Receives a framed byte stream over a valid/ready link: a 16-bit word count, 4 bytes per word, and a 1-byte XOR checksum.
- Assembles big-endian 32-bit instructions and writes them into instruction memory starting at word address 0.
- Holds the CPU in reset until the image is fully written and the checksum verifies.

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_loader_if.sv | 28 ++
 rtl/imem_loader_word_assembler.sv | 38 +++
 rtl/imem_loader.sv | 127 ++++++++++++
 tb/tb_imem_loader.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states and
// framing constants.
package imem_loader_pkg;

   localparam int unsigned LEN_WIDTH      = 16;
   localparam int unsigned BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and CPU-hold status of
// the loader, bundled as one interface.
interface imem_loader_if #(
   parameter int unsigned ADDR_WIDTH = 10
);
   logic [7:0]            in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_wdata;
   logic                  cpu_hold;
   logic                  done;
   logic                  error;
   logic [ADDR_WIDTH:0]   words_loaded;

   modport slave (
      input  in_data, in_valid,
      output in_ready, mem_we, mem_addr, mem_wdata,
             cpu_hold, done, error, words_loaded
   );

   modport master (
      output in_data, in_valid,
      input  in_ready, mem_we, mem_addr, mem_wdata,
             cpu_hold, done, error, words_loaded
   );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Collects stream bytes into a big-endian 32-bit word; word_ready marks the
// byte that completes a word, with word already valid in that cycle.
module imem_loader_word_assembler
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        byte_valid,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_ready
);

   logic [1:0]  idx_q, idx_d;
   logic [23:0] shift_q, shift_d;

   always_comb begin
      idx_d      = idx_q;
      shift_d    = shift_q;
      word       = {shift_q, byte_in};
      word_ready = byte_valid && (idx_q == 2'(BYTES_PER_WORD - 1));
      if (byte_valid) begin
         shift_d = {shift_q[15:0], byte_in};
         idx_d   = idx_q + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q   <= '0;
         shift_q <= '0;
      end else begin
         idx_q   <= idx_d;
         shift_q <= shift_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Loads a framed, checksummed instruction image into instruction memory and
// holds the CPU in reset until the image is complete and verified.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic         clk,
   input  logic         rst,
   imem_loader_if.slave bus
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   state_e                state_q, state_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [ADDR_WIDTH:0]   words_q, words_d;
   logic [7:0]            csum_q, csum_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]           mem_wdata_q, mem_wdata_d;

   logic                  in_ready;
   logic                  accept;
   logic                  data_fire;
   logic [LEN_WIDTH-1:0]  len_full;
   logic [ADDR_WIDTH:0]   words_inc;
   logic [31:0]           asm_word;
   logic                  asm_ready;

   assign in_ready  = !(state_q inside {S_DONE, S_ERR});
   assign accept    = bus.in_valid && in_ready;
   assign data_fire = accept && (state_q == S_DATA);
   assign len_full  = {len_q[LEN_WIDTH-1:8], bus.in_data};
   assign words_inc = words_q + 1'b1;

   imem_loader_word_assembler u_asm (
      .clk        (clk),
      .rst        (rst),
      .byte_valid (data_fire),
      .byte_in    (bus.in_data),
      .word       (asm_word),
      .word_ready (asm_ready)
   );

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      words_d     = words_q;
      csum_d      = csum_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      case (state_q)
         S_LEN_HI: begin
            if (accept) begin
               len_d[LEN_WIDTH-1:8] = bus.in_data;
               state_d              = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            // Oversized images are rejected here, before any write is issued.
            if (accept) begin
               len_d = len_full;
               if ({1'b0, len_full} > (LEN_WIDTH + 1)'(DEPTH)) begin
                  state_d = S_ERR;
               end else if (len_full == '0) begin
                  state_d = S_CSUM;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (accept) begin
               csum_d = csum_q ^ bus.in_data;
               if (asm_ready) begin
                  mem_we_d    = 1'b1;
                  mem_addr_d  = words_q[ADDR_WIDTH-1:0];
                  mem_wdata_d = asm_word;
                  words_d     = words_inc;
                  if (LEN_WIDTH'(words_inc) == len_q) begin
                     state_d = S_CSUM;
                  end
               end
            end
         end
         S_CSUM: begin
            if (accept) begin
               state_d = (bus.in_data == csum_q) ? S_DONE : S_ERR;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_LEN_HI;
         len_q       <= '0;
         words_q     <= '0;
         csum_q      <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         words_q     <= words_d;
         csum_q      <= csum_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign bus.in_ready     = in_ready;
   assign bus.mem_we       = mem_we_q;
   assign bus.mem_addr     = mem_addr_q;
   assign bus.mem_wdata    = mem_wdata_q;
   assign bus.done         = (state_q == S_DONE);
   assign bus.error        = (state_q == S_ERR);
   assign bus.cpu_hold     = (state_q != S_DONE);
   assign bus.words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table vectors, hand-written timing sequences and
// random frames checked against a frame-level reference model.
module tb_imem_loader;

   localparam int unsigned AW    = 4;
   localparam int          DEPTH = 1 << AW;

   typedef logic [AW+31:0] wr_t;

   typedef struct {
      string        name;
      int           n;
      logic [95:0]  bytes;
      bit           e_done;
      bit           e_err;
      int           e_words;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   imem_loader_if #(.ADDR_WIDTH(AW)) bus ();
   imem_loader #(.ADDR_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

   int  passes = 0;
   int  total  = 0;
   wr_t got_q[$];
   wr_t exp_q[$];
   bit  exp_done, exp_err;
   int  exp_words;
   bit  hold_violation = 1'b0;

   always @(negedge clk) begin
      if (bus.mem_we) begin
         got_q.push_back({bus.mem_addr, bus.mem_wdata});
         if (!bus.cpu_hold) hold_violation = 1'b1;
      end
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      tick();
      tick();
      rst = 1'b0;
      got_q.delete();
      hold_violation = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap_pct);
      for (int g = 0; g < 4 && int'($urandom_range(99)) < gap_pct; g++) tick();
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
   endtask

   // Frame-level model: header, whole words, XOR of data bytes, verdict.
   task automatic model_frame(input logic [7:0] fr[$]);
      int         len;
      logic [7:0] x;
      exp_q.delete();
      exp_done  = 1'b0;
      exp_err   = 1'b0;
      exp_words = 0;
      if (fr.size() < 2) return;
      len = int'(fr[0]) * 256 + int'(fr[1]);
      if (len > DEPTH) begin
         exp_err = 1'b1;
         return;
      end
      x = 8'h00;
      for (int w = 0; w < len; w++) begin
         int base;
         base = 2 + 4 * w;
         if (base + 3 >= fr.size()) return;
         exp_q.push_back({AW'(w), fr[base], fr[base+1], fr[base+2], fr[base+3]});
         x = x ^ fr[base] ^ fr[base+1] ^ fr[base+2] ^ fr[base+3];
         exp_words++;
      end
      if (fr.size() > 2 + 4 * len) begin
         if (fr[2 + 4 * len] == x) exp_done = 1'b1;
         else exp_err = 1'b1;
      end
   endtask

   task automatic run_frame(input logic [7:0] fr[$], input int gap_pct, input string tag);
      model_frame(fr);
      do_reset();
      foreach (fr[i]) send_byte(fr[i], gap_pct);
      tick(); tick(); tick();
      chk({tag, "_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk($sformatf("%s_wr%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
      chk({tag, "_done"},     64'(bus.done),         64'(exp_done));
      chk({tag, "_error"},    64'(bus.error),        64'(exp_err));
      chk({tag, "_cpu_hold"}, 64'(bus.cpu_hold),     64'(!exp_done));
      chk({tag, "_in_ready"}, 64'(bus.in_ready),     64'(!(exp_done || exp_err)));
      chk({tag, "_words"},    64'(bus.words_loaded), 64'(exp_words));
      chk({tag, "_hold_ord"}, 64'(hold_violation),   64'(0));
   endtask

   vec_t vt[6];

   initial begin
      logic [7:0] fr[$];
      logic [95:0] tmp;

      vt[0] = '{"basic",    11, 96'h0002_2408_0005_2009_000A_0A, 1'b1, 1'b0, 2};
      vt[1] = '{"badcsum",  11, 96'h0002_2408_0005_2009_000A_08, 1'b0, 1'b1, 2};
      vt[2] = '{"ovf_hdr",   2, 96'h0011,                        1'b0, 1'b1, 0};
      vt[3] = '{"ovf_data",  6, 96'h0011_2408_0005,              1'b0, 1'b1, 0};
      vt[4] = '{"zero_ok",   3, 96'h000000,                      1'b1, 1'b0, 0};
      vt[5] = '{"zero_bad",  3, 96'h000001,                      1'b0, 1'b1, 0};

      // Reset values
      do_reset();
      chk("rst_in_ready", 64'(bus.in_ready),     64'(1));
      chk("rst_mem_we",   64'(bus.mem_we),       64'(0));
      chk("rst_addr",     64'(bus.mem_addr),     64'(0));
      chk("rst_wdata",    64'(bus.mem_wdata),    64'(0));
      chk("rst_cpu_hold", 64'(bus.cpu_hold),     64'(1));
      chk("rst_done",     64'(bus.done),         64'(0));
      chk("rst_error",    64'(bus.error),        64'(0));
      chk("rst_words",    64'(bus.words_loaded), 64'(0));

      // Table vectors
      for (int v = 0; v < 6; v++) begin
         fr.delete();
         for (int i = 0; i < vt[v].n; i++) begin
            tmp = vt[v].bytes >> (8 * (vt[v].n - 1 - i));
            fr.push_back(tmp[7:0]);
         end
         run_frame(fr, 0, vt[v].name);
         chk({vt[v].name, "_tbl_done"},  64'(bus.done),         64'(vt[v].e_done));
         chk({vt[v].name, "_tbl_err"},   64'(bus.error),        64'(vt[v].e_err));
         chk({vt[v].name, "_tbl_words"}, 64'(bus.words_loaded), 64'(vt[v].e_words));
      end

      // Basic load cycle timing
      do_reset();
      fr = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A};
      for (int i = 0; i < 6; i++) send_byte(fr[i], 0);
      chk("t_we0",    64'(bus.mem_we),       64'(1));
      chk("t_addr0",  64'(bus.mem_addr),     64'(0));
      chk("t_data0",  64'(bus.mem_wdata),    64'h24080005);
      chk("t_words0", 64'(bus.words_loaded), 64'(1));
      for (int i = 6; i < 10; i++) send_byte(fr[i], 0);
      chk("t_we1",    64'(bus.mem_we),       64'(1));
      chk("t_addr1",  64'(bus.mem_addr),     64'(1));
      chk("t_data1",  64'(bus.mem_wdata),    64'h2009000A);
      bus.in_data  = 8'h0A;
      bus.in_valid = 1'b1;
      chk("t_done_before", 64'(bus.done),     64'(0));
      chk("t_hold_before", 64'(bus.cpu_hold), 64'(1));
      tick();
      bus.in_valid = 1'b0;
      chk("t_done_after",  64'(bus.done),     64'(1));
      chk("t_hold_after",  64'(bus.cpu_hold), 64'(0));
      chk("t_ready_after", 64'(bus.in_ready), 64'(0));
      chk("t_we_after",    64'(bus.mem_we),   64'(0));
      tick();
      chk("t_nwrites", 64'(got_q.size()), 64'(2));

      // Gapped basic load
      fr.push_back(8'h0A);
      for (int r = 0; r < 3; r++) run_frame(fr, 50, $sformatf("gap%0d", r));

      // Largest legal image: 16 words, last write at address 15
      fr = '{8'h00, 8'h10};
      for (int i = 0; i < 4 * DEPTH; i++) fr.push_back(8'($urandom));
      begin
         logic [7:0] x;
         x = 8'h00;
         for (int i = 2; i < fr.size(); i++) x ^= fr[i];
         fr.push_back(x);
      end
      run_frame(fr, 10, "full");
      if (got_q.size() > 0) chk("full_last_addr", 64'(got_q[$] >> 32), 64'(DEPTH - 1));
      else chk("full_last_addr", 64'(got_q.size()), 64'(DEPTH));

      // Reset mid-load, then a fresh one-word image
      do_reset();
      fr = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09};
      foreach (fr[i]) send_byte(fr[i], 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      got_q.delete();
      chk("mid_rst_words", 64'(bus.words_loaded), 64'(0));
      fr = '{8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
      foreach (fr[i]) send_byte(fr[i], 0);
      tick(); tick();
      chk("mid_nwrites", 64'(got_q.size()), 64'(1));
      if (got_q.size() > 0) chk("mid_wr0", 64'(got_q[0]), 64'({4'h0, 32'hFFFFFFFF}));
      chk("mid_done",  64'(bus.done),         64'(1));
      chk("mid_words", 64'(bus.words_loaded), 64'(1));

      // Random frames against the model
      for (int r = 0; r < 12; r++) begin
         int len;
         logic [7:0] x;
         len = ($urandom_range(5) == 0) ? int'($urandom_range(DEPTH + 4, DEPTH + 1))
                                        : int'($urandom_range(DEPTH, 0));
         fr = '{8'(len >> 8), 8'(len)};
         x = 8'h00;
         if (len <= DEPTH) begin
            for (int i = 0; i < 4 * len; i++) begin
               fr.push_back(8'($urandom));
               x ^= fr[$];
            end
            if ($urandom_range(3) == 0) x ^= 8'(1 << $urandom_range(7));
            fr.push_back(x);
         end
         run_frame(fr, 30, $sformatf("rnd%0d", r));
      end

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
